// File: rtl/mc_ctrl_pkg.sv
// Purpose: shared types and encodings for the multicycle control unit (states, opcodes, ALU/mux codes).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_DECODE,
        ST_EX_ALU,
        ST_EX_SH,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } state_t;

    // Which execution path DECODE hands the instruction to.
    typedef enum logic [2:0] {
        CLS_SHIFT,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [3:0] OP_SHIFT = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_NAND  = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_ORI   = 4'h6;
    localparam logic [3:0] OP_LW    = 4'h7;
    localparam logic [3:0] OP_SW    = 4'h8;
    localparam logic [3:0] OP_BEQ   = 4'h9;
    localparam logic [3:0] OP_BNE   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_BR    = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;
    localparam logic [1:0] ALU_OR   = 2'b11;

    localparam logic [2:0] SRCB_TWO      = 3'b000;
    localparam logic [2:0] SRCB_REG      = 3'b001;
    localparam logic [2:0] SRCB_SEXT     = 3'b010;
    localparam logic [2:0] SRCB_ZEXT     = 3'b011;
    localparam logic [2:0] SRCB_SEXT_SH1 = 3'b100;
    localparam logic [2:0] SRCB_ZEXT12   = 3'b101;

    localparam logic [1:0] REGA_RTYPE = 2'b00;
    localparam logic [1:0] REGA_IMM   = 2'b01;
    localparam logic [1:0] REGA_MEM   = 2'b10;

    // Everything the FSM needs to know about the current opcode.
    typedef struct packed {
        op_class_t  cls;
        logic [1:0] reg_a;
        logic       reg_b;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [2:0] alu_src_b;
        logic       eqb;
        logic       read3;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Purpose: combinational opcode decode into execution class and per-opcode datapath fields.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows opcode every cycle.
module mc_opcode_decode
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic [3:0] opcode,
    output dec_t       dec
);

    // Map the opcode onto its class and the operand/ALU fields used by later states.
    always_comb begin
        dec           = '0;
        dec.cls       = CLS_ILLEGAL;
        dec.reg_a     = REGA_RTYPE;
        dec.alu_op    = ALU_ADD;
        dec.alu_src_b = SRCB_TWO;
        if (opcode == HALT_OP) begin
            dec.cls = CLS_HALT;
        end else begin
            case (opcode)
                OP_SHIFT: dec.cls = CLS_SHIFT;
                OP_ADD, OP_SUB, OP_NAND, OP_OR: begin
                    dec.cls       = CLS_ALU;
                    dec.alu_src_b = SRCB_REG;
                    // ADD..OR are consecutive so the ALU code is opcode-1.
                    dec.alu_op    = 2'(opcode - 4'd1);
                end
                OP_ADDI: begin
                    dec.cls       = CLS_ALU;
                    dec.reg_a     = REGA_IMM;
                    dec.alu_src_b = SRCB_SEXT;
                    dec.alu_op    = ALU_ADD;
                end
                OP_ORI: begin
                    dec.cls       = CLS_ALU;
                    dec.reg_a     = REGA_IMM;
                    dec.alu_src_b = SRCB_ZEXT;
                    dec.alu_op    = ALU_OR;
                end
                OP_LW: begin
                    dec.cls       = CLS_LOAD;
                    dec.reg_a     = REGA_MEM;
                    dec.reg_dst   = 1'b1;
                    dec.alu_src_b = SRCB_SEXT;
                end
                OP_SW: begin
                    dec.cls       = CLS_STORE;
                    dec.reg_a     = REGA_MEM;
                    dec.reg_b     = 1'b1;
                    dec.alu_src_b = SRCB_SEXT;
                end
                OP_BEQ, OP_BNE: begin
                    dec.cls       = CLS_BRANCH;
                    dec.read3     = 1'b1;
                    dec.eqb       = (opcode == OP_BNE);
                    dec.alu_src_b = SRCB_REG;
                    dec.alu_op    = ALU_SUB;
                end
                OP_JMP: begin
                    dec.cls       = CLS_JUMP;
                    dec.alu_src_b = SRCB_ZEXT12;
                end
                OP_BR: begin
                    dec.cls       = CLS_JUMP;
                    dec.alu_src_b = SRCB_SEXT_SH1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Purpose: Moore control FSM sequencing fetch/decode/execute/memory/writeback plus program-load mode and halt.
// Latency: 1 cycle per state; CPI 4 ALU/shift/SW, 5 LW, 3 branch/jump, 2 to reach HALT.
// Backpressure: none; LOAD writes only on prog_valid, IDLE waits for start/prog_en, HALT waits for rst.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] HALT_OP       = 4'hF,
    parameter bit         ILLEGAL_HALTS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       prog_en,
    input  logic       prog_valid,
    input  logic [3:0] opcode,
    output logic       pc_wr,
    output logic       pc_src,
    output logic       eqb,
    output logic       instr_wr,
    output logic       pc_clr,
    output logic [1:0] regA,
    output logic       regB,
    output logic       reg_dst,
    output logic       read3,
    output logic       reg_wr,
    output logic       mem_to_reg,
    output logic       alu_srcA,
    output logic       output_cont,
    output logic [2:0] alu_srcB,
    output logic [1:0] alu_op,
    output logic       memr,
    output logic       memw,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    state_t state;
    state_t state_nxt;
    dec_t   dec;
    logic   illegal_q;
    logic   in_instr;

    mc_opcode_decode #(
        .HALT_OP (HALT_OP)
    ) u_dec (
        .opcode (opcode),
        .dec    (dec)
    );

    // State register with synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Remember that HALT was entered through an illegal opcode rather than HALT_OP.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (ILLEGAL_HALTS && state == ST_DECODE && dec.cls == CLS_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    // Operands stay selected from DECODE to the last state since the register file re-reads each clock.
    assign in_instr = (state != ST_IDLE) && (state != ST_LOAD) &&
                      (state != ST_FETCH) && (state != ST_HALT);

    // Next-state and Moore outputs; everything stays 0 while rst is high so nothing commits on the reset edge.
    always_comb begin
        state_nxt   = state;
        pc_wr       = 1'b0;
        pc_src      = 1'b0;
        eqb         = 1'b0;
        instr_wr    = 1'b0;
        pc_clr      = 1'b0;
        regA        = REGA_RTYPE;
        regB        = 1'b0;
        reg_dst     = 1'b0;
        read3       = 1'b0;
        reg_wr      = 1'b0;
        mem_to_reg  = 1'b0;
        alu_srcA    = 1'b0;
        output_cont = 1'b0;
        alu_srcB    = SRCB_TWO;
        alu_op      = ALU_ADD;
        memr        = 1'b0;
        memw        = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;

        if (!rst) begin
            busy = (state != ST_IDLE) && (state != ST_HALT);
            if (in_instr) begin
                regA    = dec.reg_a;
                regB    = dec.reg_b;
                reg_dst = dec.reg_dst;
            end

            case (state)
                ST_IDLE: begin
                    if (prog_en) begin
                        state_nxt = ST_LOAD;
                        pc_clr    = 1'b1;
                    end else if (start) begin
                        state_nxt = ST_FETCH;
                        pc_clr    = 1'b1;
                    end
                end
                ST_LOAD: begin
                    // pc <= pc + 2 alongside the instruction-memory write.
                    instr_wr = prog_valid;
                    pc_wr    = prog_valid;
                    if (!prog_en) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    pc_wr     = 1'b1;
                    state_nxt = ST_DECODE;
                end
                ST_DECODE: begin
                    read3 = dec.read3;
                    case (dec.cls)
                        CLS_SHIFT:             state_nxt = ST_EX_SH;
                        CLS_ALU:               state_nxt = ST_EX_ALU;
                        CLS_LOAD, CLS_STORE:   state_nxt = ST_MEM_ADDR;
                        CLS_BRANCH:            state_nxt = ST_BRANCH;
                        CLS_JUMP:              state_nxt = ST_JUMP;
                        CLS_HALT:              state_nxt = ST_HALT;
                        default:               state_nxt = ILLEGAL_HALTS ? ST_HALT : ST_FETCH;
                    endcase
                end
                ST_EX_ALU: begin
                    alu_srcA  = 1'b1;
                    alu_srcB  = dec.alu_src_b;
                    alu_op    = dec.alu_op;
                    state_nxt = ST_WB;
                end
                ST_EX_SH: begin
                    alu_srcA    = 1'b1;
                    output_cont = 1'b1;
                    state_nxt   = ST_WB;
                end
                ST_WB: begin
                    reg_wr    = 1'b1;
                    state_nxt = ST_FETCH;
                end
                ST_MEM_ADDR: begin
                    alu_srcA  = 1'b1;
                    alu_srcB  = SRCB_SEXT;
                    state_nxt = (dec.cls == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD: begin
                    memr      = 1'b1;
                    state_nxt = ST_MEM_WB;
                end
                ST_MEM_WB: begin
                    reg_wr     = 1'b1;
                    mem_to_reg = 1'b1;
                    state_nxt  = ST_FETCH;
                end
                ST_MEM_WR: begin
                    memw      = 1'b1;
                    state_nxt = ST_FETCH;
                end
                ST_BRANCH: begin
                    // Datapath commits pc <= C only when eqb ^ zf.
                    alu_srcA  = 1'b1;
                    alu_srcB  = SRCB_REG;
                    alu_op    = ALU_SUB;
                    pc_src    = 1'b1;
                    eqb       = dec.eqb;
                    state_nxt = ST_FETCH;
                end
                ST_JUMP: begin
                    // Offset is added to the pc already advanced by FETCH.
                    pc_wr     = 1'b1;
                    alu_srcB  = dec.alu_src_b;
                    state_nxt = ST_FETCH;
                end
                ST_HALT: begin
                    halted  = 1'b1;
                    illegal = illegal_q;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Purpose: directed self-checking bench for mc_control_fsm with a tiny PC model driven by the control outputs.
// Latency: checks outputs 2 time units after each rising edge.
// Backpressure: n/a.
module tb_mc_control_fsm;

    localparam logic [15:0] C_TGT = 16'h0040;
    localparam logic [15:0] J_OFF = 16'h0010;

    logic       clk = 1'b0;
    logic       rst, start, prog_en, prog_valid;
    logic [3:0] opcode;
    logic       zf;

    logic       pc_wr, pc_src, eqb, instr_wr, pc_clr;
    logic [1:0] regA;
    logic       regB, reg_dst, read3, reg_wr, mem_to_reg;
    logic       alu_srcA, output_cont;
    logic [2:0] alu_srcB;
    logic [1:0] alu_op;
    logic       memr, memw, busy, halted, illegal;

    logic       n_pc_wr, n_pc_src, n_eqb, n_instr_wr, n_pc_clr;
    logic [1:0] n_regA;
    logic       n_regB, n_reg_dst, n_read3, n_reg_wr, n_mem_to_reg;
    logic       n_alu_srcA, n_output_cont;
    logic [2:0] n_alu_srcB;
    logic [1:0] n_alu_op;
    logic       n_memr, n_memw, n_busy, n_halted, n_illegal;

    logic [23:0] outs;
    logic [15:0] pc_m;
    int          n_chk  = 0;
    int          n_fail = 0;

    assign outs = {pc_wr, pc_src, eqb, instr_wr, pc_clr, regA, regB, reg_dst, read3,
                   reg_wr, mem_to_reg, alu_srcA, output_cont, alu_srcB, alu_op,
                   memr, memw, busy, halted, illegal};

    mc_control_fsm #(.HALT_OP(4'hF), .ILLEGAL_HALTS(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_en(prog_en), .prog_valid(prog_valid),
        .opcode(opcode), .pc_wr(pc_wr), .pc_src(pc_src), .eqb(eqb), .instr_wr(instr_wr),
        .pc_clr(pc_clr), .regA(regA), .regB(regB), .reg_dst(reg_dst), .read3(read3),
        .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .alu_srcA(alu_srcA),
        .output_cont(output_cont), .alu_srcB(alu_srcB), .alu_op(alu_op), .memr(memr),
        .memw(memw), .busy(busy), .halted(halted), .illegal(illegal)
    );

    mc_control_fsm #(.HALT_OP(4'hF), .ILLEGAL_HALTS(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .start(start), .prog_en(prog_en), .prog_valid(prog_valid),
        .opcode(opcode), .pc_wr(n_pc_wr), .pc_src(n_pc_src), .eqb(n_eqb),
        .instr_wr(n_instr_wr), .pc_clr(n_pc_clr), .regA(n_regA), .regB(n_regB),
        .reg_dst(n_reg_dst), .read3(n_read3), .reg_wr(n_reg_wr), .mem_to_reg(n_mem_to_reg),
        .alu_srcA(n_alu_srcA), .output_cont(n_output_cont), .alu_srcB(n_alu_srcB),
        .alu_op(n_alu_op), .memr(n_memr), .memw(n_memw), .busy(n_busy),
        .halted(n_halted), .illegal(n_illegal)
    );

    always #5 clk = ~clk;

    // Minimal datapath PC: clear, +2 / jump offset on pc_wr, branch target when eqb ^ zf.
    always @(posedge clk) begin
        if (pc_clr)
            pc_m <= 16'h0000;
        else if (pc_wr)
            pc_m <= pc_m + ((alu_srcB == 3'b000) ? 16'd2 : J_OFF);
        else if (pc_src && (eqb ^ zf))
            pc_m <= C_TGT;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // FETCH signature: {pc_wr, alu_srcA, alu_srcB, busy, instr_wr, reg_wr, memw}
    task automatic chk_fetch(input string tag);
        chk(tag, 32'({pc_wr, alu_srcA, alu_srcB, busy, instr_wr, reg_wr, memw}), 32'b1_0_000_1_0_0_0);
    endtask

    initial begin
        logic [3:0] vpat;
        logic [15:0] pc_exp [4];
        int n_iw, n_pw, n_clr, n_mr, n_mw;

        vpat = 4'b1101;   // cycle 0 = bit 0
        pc_exp[0] = 16'd2; pc_exp[1] = 16'd2; pc_exp[2] = 16'd4; pc_exp[3] = 16'd6;

        // Reset: outputs gated even with start and prog_en high.
        rst = 1'b1; start = 1'b1; prog_en = 1'b1; prog_valid = 1'b0; opcode = 4'h0; zf = 1'b0;
        #1;
        chk("rst_outs0", 32'(outs), 32'd0);
        step();
        chk("rst_outs1", 32'(outs), 32'd0);

        // IDLE -> LOAD with one pc_clr pulse.
        rst = 1'b0; start = 1'b0; prog_en = 1'b1;
        #1;
        chk("idle_pc_clr", 32'({pc_clr, busy}), 32'b10);
        step();
        chk("load_pc0", 32'(pc_m), 32'd0);
        n_iw = 0; n_pw = 0; n_clr = 0;
        for (int i = 0; i < 4; i++) begin
            prog_valid = vpat[i];
            #1;
            n_iw  += int'(instr_wr);
            n_pw  += int'(pc_wr);
            n_clr += int'(pc_clr);
            step();
            chk($sformatf("load_pc%0d", i + 1), 32'(pc_m), 32'(pc_exp[i]));
        end
        chk("load_instr_wr_cnt", 32'(n_iw), 32'd3);
        chk("load_pc_wr_cnt", 32'(n_pw), 32'd3);
        chk("load_pc_clr_cnt", 32'(n_clr), 32'd0);
        prog_valid = 1'b0; prog_en = 1'b0;
        #1;
        chk("load_exit", 32'({instr_wr, pc_wr, busy}), 32'b001);
        step();
        chk("idle_after_load", 32'(outs), 32'd0);

        // ADD: FETCH, DECODE, EX_ALU, WB.
        opcode = 4'h1; start = 1'b1;
        #1;
        chk("add_start_clr", 32'(pc_clr), 32'd1);
        step(); start = 1'b0; #1;
        chk_fetch("add_fetch");
        step(); #1;
        chk("add_decode", 32'({regA, regB, reg_dst, pc_wr, reg_wr, busy}), 32'b00_0_0_0_0_1);
        step(); #1;
        chk("add_ex", 32'({alu_srcA, alu_srcB, alu_op, reg_wr, busy}), 32'b1_001_00_0_1);
        step(); #1;
        chk("add_wb", 32'({reg_wr, mem_to_reg, busy}), 32'b101);

        // LW: 5 cycles.
        step(); opcode = 4'h7; #1;
        chk_fetch("lw_fetch");
        chk("lw_pc", 32'(pc_m), 32'd2);
        n_mr = 0; n_mw = 0;
        step(); #1;
        chk("lw_decode", 32'({regA, reg_dst}), 32'b10_1);
        step(); #1;
        chk("lw_addr", 32'({alu_srcA, alu_srcB, alu_op, memr}), 32'b1_010_00_0);
        step(); #1;
        chk("lw_rd", 32'({memr, memw, reg_wr, regA, reg_dst}), 32'b1_0_0_10_1);
        step(); #1;
        chk("lw_wb", 32'({reg_wr, mem_to_reg, memr, reg_dst}), 32'b1_1_0_1);

        // SW: 4 cycles, exactly one memw and no memr.
        step(); opcode = 4'h8; #1;
        chk_fetch("sw_fetch");
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            if (i == 0) chk("sw_decode_regb", 32'({regA, regB}), 32'b10_1);
            n_mr += int'(memr);
            n_mw += int'(memw);
        end
        chk("sw_memw_cnt", 32'(n_mw), 32'd1);
        chk("sw_memr_cnt", 32'(n_mr), 32'd0);

        // BEQ with equal operands: taken.
        step(); opcode = 4'h9; zf = 1'b1; #1;
        chk_fetch("beq_fetch");
        step(); #1;
        chk("beq_decode_read3", 32'(read3), 32'd1);
        step(); #1;
        chk("beq_branch", 32'({pc_src, eqb, alu_srcA, alu_srcB, alu_op, pc_wr}), 32'b1_0_1_001_01_0);

        // BNE with equal operands: not taken.
        step(); opcode = 4'hA; #1;
        chk_fetch("bne_fetch");
        chk("beq_pc_taken", 32'(pc_m), 32'(C_TGT));
        step(); #1;
        step(); #1;
        chk("bne_branch", 32'({pc_src, eqb}), 32'b11);

        // JMP relative to the incremented pc.
        step(); opcode = 4'hB; #1;
        chk_fetch("jmp_fetch");
        chk("bne_pc_stays", 32'(pc_m), 32'h42);
        step(); #1;
        step(); #1;
        chk("jmp_jump", 32'({pc_wr, alu_srcA, alu_srcB, alu_op}), 32'b1_0_101_00);

        // SHIFT.
        step(); opcode = 4'h0; #1;
        chk_fetch("sh_fetch");
        chk("jmp_pc", 32'(pc_m), 32'h54);
        step(); #1;
        step(); #1;
        chk("sh_ex", 32'({alu_srcA, output_cont, reg_wr}), 32'b110);
        step(); #1;
        chk("sh_wb", 32'({reg_wr, output_cont}), 32'b10);

        // ADDI with reset asserted during WB.
        step(); opcode = 4'h5; #1;
        chk_fetch("addi_fetch");
        step(); #1;
        step(); #1;
        chk("addi_ex", 32'({regA, alu_srcB, alu_op}), 32'b01_010_00);
        step(); #1;
        chk("addi_wb_pre", 32'({reg_wr, regA}), 32'b1_01);
        rst = 1'b1; #1;
        chk("addi_wb_rst", 32'(outs), 32'd0);
        step();
        rst = 1'b0; #1;
        chk("post_rst_idle", 32'(outs), 32'd0);

        // Illegal opcode D: halts on dut, NOP on dut_nop.
        start = 1'b1; opcode = 4'hD; #1;
        chk("ill_idle_clr", 32'({pc_clr, busy}), 32'b10);
        step(); start = 1'b0; #1;
        chk_fetch("ill_fetch");
        step(); #1;
        chk("ill_decode_busy", 32'(busy), 32'd1);
        step(); #1;
        chk("ill_halt", 32'({halted, illegal, busy}), 32'b110);
        chk("nop_fetch", 32'({n_pc_wr, n_busy, n_halted, n_illegal, n_reg_wr, n_memw}), 32'b110000);
        start = 1'b1;
        step(); #1;
        chk("ill_halt_stays", 32'({halted, illegal, busy, pc_wr}), 32'b1100);

        // HALT opcode: two cycles to HALT, illegal stays low.
        rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b1; opcode = 4'hF; #1;
        chk("halt_idle_clr", 32'(pc_clr), 32'd1);
        step(); start = 1'b0; #1;
        chk_fetch("halt_fetch");
        step(); #1;
        step(); #1;
        chk("halt_state", 32'({halted, illegal, busy}), 32'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
